cacheline_adaptor: RTL and testbench

Line-to-burst adaptor directly downstream of the L1 cache data array (4 x 256-bit lines) and upstream of physical memory.
- Line fills: collects BEATS consecutive 64-bit memory beats into one 256-bit line, which the cache controller writes into the data array.
- Write-backs: splits a 256-bit victim line read from the data array into 64-bit beats for memory.
- One transaction in flight at a time.

---
 rtl/cache_types_pkg.sv | 19 +
 rtl/cacheline_adaptor.sv | 125 ++++++++++++
 tb/tb_cacheline_adaptor.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_types_pkg.sv
// Shared widths, derived constants and FSM state type for the cache line adaptor.
// Holds LINE_WIDTH/BURST_WIDTH/ADDR_WIDTH, BEATS, the line offset width and adaptor_state_t.
package cache_types_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int ADDR_WIDTH  = 32;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_WIDTH   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Line-to-burst adaptor: gathers BEATS memory beats into a fill line, splits a
// victim line into beats for write-back; one transaction in flight.
// Ports: clk, rst (async high); cache side line_i/line_o, address_i, read_i,
// write_i, resp_o; memory side burst_i/burst_o, address_o, read_o, write_o,
// resp_i; rd_count_o/wr_count_o perf counters (ADAPTOR_PERF_CNT_EN, else 0).
module cacheline_adaptor
  import cache_types_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i,
  output logic [31:0]            rd_count_o,
  output logic [31:0]            wr_count_o
);

  adaptor_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic                  last_beat;

  assign addr_aligned = {address_i[ADDR_WIDTH-1:OFFSET_BITS],
                         OFFSET_BITS'(0)};
  assign last_beat = resp_i && (cnt_q == CNT_WIDTH'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  // BEATS is a power of two, so the beat counter wraps to 0 on the last beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          state_d = WR;
          buf_d   = line_i;
          addr_d  = addr_aligned;
        end else if (read_i) begin
          state_d = RD;
          addr_d  = addr_aligned;
        end
      end
      RD: begin
        if (resp_i) begin
          buf_d[cnt_q*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_o    = (state_q == RD);
    write_o   = (state_q == WR);
    resp_o    = (state_q == DONE);
    line_o    = buf_q;
    address_o = addr_q;
    burst_o   = '0;
    if (state_q == WR) burst_o = buf_q[cnt_q*BURST_WIDTH +: BURST_WIDTH];
  end

`ifdef ADAPTOR_PERF_CNT_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (last_beat && state_q == RD) rd_cnt_d = rd_cnt_q + 32'd1;
    if (last_beat && state_q == WR) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`else
  assign rd_count_o = '0;
  assign wr_count_o = '0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: vector table, hand sequences
// (read+write collision, mid-fill reset) and random transactions vs a model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;
  logic [31:0]  rd_count_o, wr_count_o;

  cacheline_adaptor dut (
    .clk        (clk),
    .rst        (rst),
    .line_i     (line_i),
    .line_o     (line_o),
    .address_i  (address_i),
    .read_i     (read_i),
    .write_i    (write_i),
    .resp_o     (resp_o),
    .burst_i    (burst_i),
    .burst_o    (burst_o),
    .address_o  (address_o),
    .read_o     (read_o),
    .write_o    (write_o),
    .resp_i     (resp_i),
    .rd_count_o (rd_count_o),
    .wr_count_o (wr_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [15:0]  pat;
    int           plen;
    logic [31:0]  exp_addr;
    int           exp_busy;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int m_rd = 0;
  int m_wr = 0;

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Busy cycles = cycles until the 4th accepted beat; pattern bits past
  // plen are treated as resp_i high.
  function automatic int model_busy(input logic [15:0] pat, input int plen);
    int ones = 0;
    int c = 0;
    while (ones < 4) begin
      if (c >= plen || pat[c]) ones++;
      c++;
    end
    return c;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".read_o"}, read_o, 0);
    chk({tag, ".write_o"}, write_o, 0);
    chk({tag, ".resp_o"}, resp_o, 0);
    chk({tag, ".burst_o"}, burst_o, 0);
    chk({tag, ".address_o"}, address_o, 0);
    chk({tag, ".line_o"}, line_o, 0);
    chk({tag, ".rd_count"}, rd_count_o, 0);
    chk({tag, ".wr_count"}, wr_count_o, 0);
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_txn(input vec_t v, input bit rd_too);
    int idx = 0;
    int cyc = 0;
    int busy = 0;
    logic r;
    address_i = v.addr;
    line_i    = v.wr ? v.data : rand_line();
    write_i   = v.wr;
    read_i    = !v.wr || rd_too;
    resp_i    = 1'b0;
    @(negedge clk);
    while (idx < 4 && cyc < 64) begin
      chk("busy.read_o", read_o, !v.wr);
      chk("busy.write_o", write_o, v.wr);
      chk("busy.address_o", address_o, v.exp_addr);
      chk("busy.resp_o", resp_o, 0);
      busy++;
      r = (cyc < v.plen) ? v.pat[cyc] : 1'b1;
      resp_i  = r;
      burst_i = v.wr ? {$urandom, $urandom} : v.data[idx*64 +: 64];
      if (v.wr && r) chk("burst_o", burst_o, v.data[idx*64 +: 64]);
      @(negedge clk);
      if (r) idx++;
      cyc++;
    end
    chk("beats_done", idx, 4);
    resp_i  = 1'($urandom);
    burst_i = {$urandom, $urandom};
    chk("latency", busy, v.exp_busy);
    chk("done.resp_o", resp_o, 1);
    chk("done.read_o", read_o, 0);
    chk("done.write_o", write_o, 0);
    chk("done.address_o", address_o, v.exp_addr);
    if (!v.wr) begin
      chk("done.line_o", line_o, v.data);
      m_rd++;
    end else begin
      m_wr++;
    end
    @(negedge clk);
    chk("pulse.resp_o", resp_o, 0);
    if (!v.wr) chk("hold.line_o", line_o, v.data);
    write_i = 1'b0;
    read_i  = rd_too;
    resp_i  = 1'b0;
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{0, 32'h1234_567F,
               {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}},
               16'h0, 0, 32'h1234_5660, 4};
    tbl[1] = '{1, 32'h8000_0020,
               {64'hD3D3_0003_A5A5_3333, 64'hD2D2_0002_A5A5_2222,
                64'hD1D1_0001_A5A5_1111, 64'hD0D0_0000_A5A5_0000},
               16'h0, 0, 32'h8000_0020, 4};
    tbl[2] = '{0, 32'hFFFF_FFFF,
               {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101},
               16'h0059, 7, 32'hFFFF_FFE0, 7};
    tbl[3] = '{1, 32'h0000_001F,
               {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
               16'h0036, 6, 32'h0000_0000, 6};
    tbl[4] = '{0, 32'hABCD_EF40,
               {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                64'hFFFF_EEEE_DDDD_CCCC, 64'hBBBB_AAAA_9999_0000},
               16'h0000, 3, 32'hABCD_EF40, 7};

    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b0);

    // Read and write requested together: write first, read after DONE.
    rv = '{1, 32'h0000_4444, rand_line(), 16'h0, 0, 32'h0000_4440, 4};
    run_txn(rv, 1'b1);
    rv = '{0, 32'h0000_4444, rand_line(), 16'h0, 0, 32'h0000_4440, 4};
    run_txn(rv, 1'b0);

    // Reset two beats into a fill.
    address_i = 32'h5555_5555; read_i = 1; resp_i = 0;
    @(negedge clk);
    resp_i = 1; burst_i = 64'hBAD0_BAD0_BAD0_0000;
    @(negedge clk);
    burst_i = 64'hBAD0_BAD0_BAD0_0001;
    @(negedge clk);
    resp_i = 0;
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    read_i = 0;
    m_rd = 0;
    m_wr = 0;
    @(negedge clk);
    chk("abort.resp_o", resp_o, 0);
    rst = 1'b0;
    @(negedge clk);
    rv = '{0, 32'h0000_0100,
           {64'h4D4D_4D4D_4D4D_4D4D, 64'h3C3C_3C3C_3C3C_3C3C,
            64'h2B2B_2B2B_2B2B_2B2B, 64'h1A1A_1A1A_1A1A_1A1A},
           16'h0, 0, 32'h0000_0100, 4};
    run_txn(rv, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rv.wr   = 1'($urandom);
      rv.addr = $urandom;
      rv.data = rand_line();
      rv.pat  = 16'($urandom_range(0, 255));
      rv.plen = 8;
      rv.exp_addr = rv.addr - (rv.addr % 32);
      rv.exp_busy = model_busy(rv.pat, rv.plen);
      run_txn(rv, 1'b0);
    end

`ifdef ADAPTOR_PERF_CNT_EN
    chk("rd_count", rd_count_o, 32'(m_rd));
    chk("wr_count", wr_count_o, 32'(m_wr));
`else
    chk("rd_count", rd_count_o, 0);
    chk("wr_count", wr_count_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
